// File: rtl/shift_control_unit_if.sv
// Push-button request / register-unit control bundle for the shift controller.
interface shift_control_unit_if #(
  parameter int unsigned CNT_W = 3
) ();
  logic             LoadA;
  logic             LoadB;
  logic             Execute;
  logic             Ld_A;
  logic             Ld_B;
  logic             Shift_En;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Count;

  // Request side (buttons / bench)
  modport master (
    output LoadA, LoadB, Execute,
    input  Ld_A, Ld_B, Shift_En, Busy, Done, Count
  );

  // Controller side
  modport slave (
    input  LoadA, LoadB, Execute,
    output Ld_A, Ld_B, Shift_En, Busy, Done, Count
  );
endinterface

// File: rtl/shift_control_unit.sv
// Sequencer for the bit-serial compute-and-shift datapath: gates load requests,
// runs exactly NUM_BITS shift cycles per Execute press, then waits for release.
module shift_control_unit #(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned CNT_W    = $clog2(NUM_BITS)
) (
  input logic                 Clk,
  input logic                 Reset,
  shift_control_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(NUM_BITS - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  // Marks the first HOLD cycle so Done pulses once even if Execute stays held
  logic             r_first_hold, w_first_hold_next;

  // State, counter and first-hold flag; reset aborts any run immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_first_hold <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_first_hold <= w_first_hold_next;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_first_hold_next = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.Execute) begin
          w_state_next = StShift;
          w_count_next = '0;
        end
      end
      StShift: begin
        if (r_count == LastCount) begin
          w_state_next      = StHold;
          w_count_next      = '0;
          w_first_hold_next = 1'b1;
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end
      StHold: begin
        // Held button keeps us here so one press yields one operation
        if (!bus.Execute) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_count_next = '0;
      end
    endcase
  end

  // Output decode; everything forced low while Reset is high
  always_comb begin
    bus.Ld_A     = 1'b0;
    bus.Ld_B     = 1'b0;
    bus.Shift_En = 1'b0;
    bus.Busy     = 1'b0;
    bus.Done     = 1'b0;
    if (!Reset) begin
      case (r_state)
        StIdle: begin
          // Execute wins over simultaneous loads
          if (!bus.Execute) begin
            bus.Ld_A = bus.LoadA;
            bus.Ld_B = bus.LoadB;
          end
        end
        StShift: begin
          bus.Shift_En = 1'b1;
          bus.Busy     = 1'b1;
        end
        StHold: begin
          bus.Busy = 1'b1;
          bus.Done = r_first_hold;
        end
        default: ;
      endcase
    end
  end

  assign bus.Count = r_count;

endmodule

// File: tb/tb_shift_control_unit.sv
// Self-checking bench for shift_control_unit against a behavioural model.
module tb_shift_control_unit;
  localparam int unsigned NUM_BITS = 8;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned VW       = CNT_W + 5;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  shift_control_unit_if #(.CNT_W(CNT_W)) bus ();

  shift_control_unit #(.NUM_BITS(NUM_BITS), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: shifts still owed in this run, waiting for button release, and a
  // flag for the cycle right after the last shift.
  int m_left;
  bit m_wait;
  bit m_fin;

  logic [VW-1:0] exp_v, obs_v;

  function automatic void model_reset();
    m_left = 0;
    m_wait = 1'b0;
    m_fin  = 1'b0;
  endfunction

  // Drive inputs just after an edge, move to mid-cycle, compute expected/observed
  task automatic step(input logic la, input logic lb, input logic ex);
    logic             e_busy, e_lda, e_ldb, e_sh, e_done;
    logic [CNT_W-1:0] e_cnt;
    bus.LoadA   = la;
    bus.LoadB   = lb;
    bus.Execute = ex;
    #4;
    e_sh   = (m_left > 0);
    e_busy = e_sh || m_wait;
    e_done = m_fin;
    e_lda  = !e_busy && !ex && la;
    e_ldb  = !e_busy && !ex && lb;
    e_cnt  = e_sh ? CNT_W'(NUM_BITS - m_left) : '0;
    if (Reset) begin
      exp_v = '0;
    end else begin
      exp_v = {e_lda, e_ldb, e_sh, e_busy, e_done, e_cnt};
    end
    obs_v = {bus.Ld_A, bus.Ld_B, bus.Shift_En, bus.Busy, bus.Done, bus.Count};
  endtask

  // Advance through the rising edge and update the model from sampled inputs
  task automatic tick();
    @(posedge Clk);
    if (Reset) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_wait = 1'b1;
        m_fin  = 1'b1;
      end
    end else if (m_wait) begin
      m_fin = 1'b0;
      if (!bus.Execute) m_wait = 1'b0;
    end else if (bus.Execute) begin
      m_left = NUM_BITS;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", obs_v, exp_v);
      end
      tick();
    end
    Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_v !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", obs_v, {VW{1'b0}});
    end
    tick();
  endtask

  task automatic test_loads();
    int na = 0, nb = 0, ns = 0;
    logic [2:0] pat [3];
    pat[0] = 3'b100;
    pat[1] = 3'b010;
    pat[2] = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step(pat[i][2], pat[i][1], pat[i][0]);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL loads[%0d]: got %b expected %b", i, obs_v, exp_v);
      end
      na += int'(bus.Ld_A);
      nb += int'(bus.Ld_B);
      ns += int'(bus.Shift_En);
      tick();
    end
    checks++;
    if (na != 1 || nb != 1 || ns != 0) begin
      errors++;
      $display("FAIL load_pulses: got lda=%0d ldb=%0d sh=%0d expected 1 1 0", na, nb, ns);
    end
  endtask

  task automatic test_execute_held();
    int ns = 0, nd = 0, first = -1, last = -1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, i < 20);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL exec_held[%0d]: got %b expected %b", i, obs_v, exp_v);
      end
      if (bus.Shift_En) begin
        ns++;
        if (first < 0) first = i;
        last = i;
      end
      nd += int'(bus.Done);
      tick();
    end
    checks++;
    if (ns != 8 || first != 1 || last != 8 || nd != 1) begin
      errors++;
      $display("FAIL exec_held_run: got sh=%0d first=%0d last=%0d done=%0d expected 8 1 8 1",
               ns, first, last, nd);
    end
  endtask

  task automatic test_execute_pulse();
    int ns = 0, nd = 0;
    for (int i = 0; i < 22; i++) begin
      // Pulse at cycle 0, re-press in the IDLE cycle right after the 1-cycle HOLD
      step(1'b0, 1'b0, (i == 0) || (i == 10));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL exec_pulse[%0d]: got %b expected %b", i, obs_v, exp_v);
      end
      ns += int'(bus.Shift_En);
      nd += int'(bus.Done);
      tick();
    end
    checks++;
    if (ns != 16 || nd != 2) begin
      errors++;
      $display("FAIL exec_pulse_runs: got sh=%0d done=%0d expected 16 2", ns, nd);
    end
  endtask

  task automatic test_priority();
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.Ld_A !== 1'b0 || obs_v !== exp_v) begin
      errors++;
      $display("FAIL exec_priority: got %b expected %b", obs_v, exp_v);
    end
    tick();
    for (int i = 0; i < 11; i++) begin
      step(1'b0, i < 8, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL load_in_shift[%0d]: got %b expected %b", i, obs_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_shift();
    int nd = 0;
    step(1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      tick();
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.Count !== CNT_W'(4) || bus.Shift_En !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got count=%0d sh=%b expected 4 1", bus.Count, bus.Shift_En);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Shift_En !== 1'b0 || bus.Count !== '0 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sh=%b count=%0d busy=%b expected 0 0 0",
               bus.Shift_En, bus.Count, bus.Busy);
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL after_reset[%0d]: got %b expected %b", i, obs_v, exp_v);
      end
      nd += int'(bus.Done);
      tick();
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL no_done_after_abort: got %0d expected 0", nd);
    end
  endtask

  task automatic test_random();
    logic ex = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) ex = ~ex;
      Reset = ($urandom_range(99) == 0);
      step(1'($urandom_range(1)), 1'($urandom_range(1)), ex);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random[%0d]: got %b expected %b", i, obs_v, exp_v);
      end
      tick();
    end
    Reset = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    bus.LoadA   = 1'b0;
    bus.LoadB   = 1'b0;
    bus.Execute = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    test_reset();
    test_loads();
    test_execute_held();
    test_execute_pulse();
    test_priority();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
